// File: rtl/event_barrier_pkg.sv
// Shared definitions for the barrier bank.
// Contents: register select encodings, the completion mode type, and the bit
// positions of the fields in the mode and status registers.
package event_barrier_pkg;

    // Register select encodings on cfg_sel_i
    localparam logic [1:0] SEL_TEAM   = 2'd0;
    localparam logic [1:0] SEL_TARGET = 2'd1;
    localparam logic [1:0] SEL_MODE   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Completion mode of one barrier
    typedef enum logic {
        MODE_FULL  = 1'b0,
        MODE_COUNT = 1'b1
    } barr_mode_e;

    // Field positions inside the 32-bit register words
    localparam int unsigned MODE_BIT       = 31;
    localparam int unsigned STATUS_ARR_LSB = 0;
    localparam int unsigned STATUS_CNT_LSB = 16;
    localparam int unsigned STATUS_ERR_BIT = 31;

endpackage

// File: rtl/event_barrier_slot.sv
// One barrier: configuration registers, arrival collection and completion test.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   hit            cores whose strobe targets this barrier this cycle
//   cfg_wr         config write addressed to this barrier
//   cfg_sel        register select of the write
//   cfg_wdata      write data
//   team, target   programmed masks
//   mode, thr      programmed completion mode and count threshold
//   arr, cnt       current arrival mask and arrival count
//   fire_c         completion this cycle (combinational)
//   nonmember_c    a strobe from a core outside the team (combinational)
module event_barrier_slot
    import event_barrier_pkg::*;
#(
    parameter int unsigned NB_CORES = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NB_CORES-1:0] hit,
    input  logic                cfg_wr,
    input  logic [1:0]          cfg_sel,
    input  logic [31:0]         cfg_wdata,
    output logic [NB_CORES-1:0] team,
    output logic [NB_CORES-1:0] target,
    output barr_mode_e          mode,
    output logic [CNT_W-1:0]    thr,
    output logic [NB_CORES-1:0] arr,
    output logic [CNT_W-1:0]    cnt,
    output logic                fire_c,
    output logic                nonmember_c
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [NB_CORES-1:0] accepted;
    logic [NB_CORES-1:0] arr_next;
    logic [CNT_W-1:0]    cnt_next;
    logic [31:0]         pop;
    logic [31:0]         sum;
    logic                full_done;
    logic                count_done;

    // Only some write-data bits are meaningful for a given select
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    // Next-state arrival view and completion decision
    always_comb begin
        accepted    = hit & team;
        nonmember_c = |(hit & ~team);
        pop         = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            pop = pop + 32'(accepted[c]);
        end
        sum        = 32'(cnt) + pop;
        cnt_next   = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum);
        arr_next   = arr | accepted;
        full_done  = (team != '0) && (arr_next == team);
        count_done = (thr != '0) && (cnt_next >= thr);
        // A config write restarts the round, so it also masks the completion
        fire_c     = !cfg_wr && ((mode == MODE_FULL) ? full_done : count_done);
    end

    // Configuration and round state
    always_ff @(posedge clk) begin
        if (rst) begin
            team   <= '0;
            target <= '0;
            mode   <= MODE_FULL;
            thr    <= '0;
            arr    <= '0;
            cnt    <= '0;
        end else if (cfg_wr) begin
            arr <= '0;
            cnt <= '0;
            case (cfg_sel)
                SEL_TEAM:   team   <= cfg_wdata[NB_CORES-1:0];
                SEL_TARGET: target <= cfg_wdata[NB_CORES-1:0];
                SEL_MODE: begin
                    mode <= barr_mode_e'(cfg_wdata[MODE_BIT]);
                    thr  <= cfg_wdata[CNT_W-1:0];
                end
                default: ;
            endcase
        end else if (fire_c) begin
            // Arrivals of the completing cycle are consumed by this round
            arr <= '0;
            cnt <= '0;
        end else begin
            arr <= arr_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/event_barrier_array.sv
// Bank of NB_BARR hardware barriers feeding the cluster event map.
// Ports:
//   clk_i, rst_i         clock and synchronous active-high reset
//   trig_valid_i         per-core arrival strobe
//   trig_barr_id_i       per-core barrier index, core c at [c*BARR_ID_W +: BARR_ID_W]
//   cfg_req_i/we_i/...   register port (select, barrier, write data)
//   cfg_gnt_o            combinational grant, mirrors cfg_req_i
//   cfg_rvalid_o/rdata_o registered response one cycle after grant
//   barr_evt_o           per-core wake pulse, OR of completing target masks
//   barr_done_o          per-barrier completion pulse
//   err_o                sticky error: non-member or out-of-range arrival
module event_barrier_array
    import event_barrier_pkg::*;
#(
    parameter int unsigned NB_CORES  = 8,
    parameter int unsigned NB_BARR   = 8,
    parameter int unsigned BARR_ID_W = (NB_BARR > 1) ? $clog2(NB_BARR) : 1,
    parameter int unsigned CNT_W     = $clog2(NB_CORES + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_CORES-1:0]           trig_valid_i,
    input  logic [NB_CORES*BARR_ID_W-1:0] trig_barr_id_i,
    input  logic                          cfg_req_i,
    input  logic                          cfg_we_i,
    input  logic [BARR_ID_W-1:0]          cfg_barr_i,
    input  logic [1:0]                    cfg_sel_i,
    input  logic [31:0]                   cfg_wdata_i,
    output logic                          cfg_gnt_o,
    output logic                          cfg_rvalid_o,
    output logic [31:0]                   cfg_rdata_o,
    output logic [NB_CORES-1:0]           barr_evt_o,
    output logic [NB_BARR-1:0]            barr_done_o,
    output logic                          err_o
);

    logic [NB_CORES-1:0]  hit       [NB_BARR];
    logic [NB_CORES-1:0]  team      [NB_BARR];
    logic [NB_CORES-1:0]  target    [NB_BARR];
    barr_mode_e           mode      [NB_BARR];
    logic [CNT_W-1:0]     thr       [NB_BARR];
    logic [NB_CORES-1:0]  arr       [NB_BARR];
    logic [CNT_W-1:0]     cnt       [NB_BARR];
    logic [NB_BARR-1:0]   fire;
    logic [NB_BARR-1:0]   nonmember;
    logic [NB_BARR-1:0]   cfg_wr;
    logic [BARR_ID_W-1:0] id;
    logic                 range_err;
    logic                 err_clr;
    logic                 err_next;
    logic [NB_CORES-1:0]  evt_next;
    logic [31:0]          rdata_next;
    logic                 cfg_barr_ok;

    assign cfg_gnt_o   = cfg_req_i;
    assign cfg_barr_ok = 32'(cfg_barr_i) < NB_BARR;

    // Route each core's strobe to the barrier it names
    always_comb begin
        id        = '0;
        range_err = 1'b0;
        for (int b = 0; b < NB_BARR; b++) begin
            hit[b] = '0;
        end
        for (int c = 0; c < NB_CORES; c++) begin
            id = trig_barr_id_i[c*BARR_ID_W +: BARR_ID_W];
            if (trig_valid_i[c]) begin
                if (32'(id) < NB_BARR) begin
                    hit[id][c] = 1'b1;
                end else begin
                    range_err = 1'b1;
                end
            end
        end
    end

    // Barrier slots
    for (genvar b = 0; b < NB_BARR; b++) begin : g_slot
        assign cfg_wr[b] = cfg_req_i && cfg_we_i && (cfg_barr_i == BARR_ID_W'(b));

        event_barrier_slot #(
            .NB_CORES (NB_CORES),
            .CNT_W    (CNT_W)
        ) u_slot (
            .clk         (clk_i),
            .rst         (rst_i),
            .hit         (hit[b]),
            .cfg_wr      (cfg_wr[b]),
            .cfg_sel     (cfg_sel_i),
            .cfg_wdata   (cfg_wdata_i),
            .team        (team[b]),
            .target      (target[b]),
            .mode        (mode[b]),
            .thr         (thr[b]),
            .arr         (arr[b]),
            .cnt         (cnt[b]),
            .fire_c      (fire[b]),
            .nonmember_c (nonmember[b])
        );
    end

    // Wake targets of all completing barriers, and the sticky error update
    always_comb begin
        evt_next = '0;
        for (int b = 0; b < NB_BARR; b++) begin
            if (fire[b]) begin
                evt_next = evt_next | target[b];
            end
        end
        err_clr  = cfg_req_i && cfg_we_i && (cfg_sel_i == SEL_STATUS) &&
                   cfg_wdata_i[STATUS_ERR_BIT];
        // A new error in the clearing cycle wins over the clear
        err_next = (err_o && !err_clr) || range_err || (|nonmember);
    end

    // Register read mux; reflects state before this cycle's arrivals
    always_comb begin
        rdata_next = '0;
        if (cfg_req_i && !cfg_we_i && cfg_barr_ok) begin
            case (cfg_sel_i)
                SEL_TEAM:   rdata_next[NB_CORES-1:0] = team[cfg_barr_i];
                SEL_TARGET: rdata_next[NB_CORES-1:0] = target[cfg_barr_i];
                SEL_MODE: begin
                    rdata_next[MODE_BIT]  = (mode[cfg_barr_i] == MODE_COUNT);
                    rdata_next[CNT_W-1:0] = thr[cfg_barr_i];
                end
                default: begin
                    rdata_next[STATUS_ARR_LSB +: NB_CORES] = arr[cfg_barr_i];
                    rdata_next[STATUS_CNT_LSB +: CNT_W]    = cnt[cfg_barr_i];
                    rdata_next[STATUS_ERR_BIT]             = err_o;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            barr_done_o  <= '0;
            barr_evt_o   <= '0;
            err_o        <= 1'b0;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            barr_done_o  <= fire;
            barr_evt_o   <= evt_next;
            err_o        <= err_next;
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= rdata_next;
        end
    end

endmodule
